// File: rtl/bit_epicness_pkg.sv
// Shared types and default bus widths for the BitEpicness CPU memory subsystem.
package bit_epicness_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_latency_counter.sv
// Loadable down-counter that times one memory access; o_zero flags its last cycle.
module arb_latency_counter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises CPU data and fetch accesses onto one single-ported memory, stalling the CPU meanwhile.
// Optional single-entry fetch reuse buffer enabled by defining ARB_FETCH_REUSE_EN.
module unified_mem_arbiter
  import bit_epicness_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state, w_state_nx;
  logic              r_i_req, r_d_we;
  logic [ADDR_W-1:0] r_i_addr, r_d_addr;
  logic [DATA_W-1:0] r_d_wdata;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;

  logic              w_mem_en_nx, w_mem_we_nx;
  logic [ADDR_W-1:0] w_mem_addr_nx;
  logic [DATA_W-1:0] w_mem_wdata_nx;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic              w_cap_d, w_cap_i, w_fb_use;
  logic              w_hit;
  logic [DATA_W-1:0] w_fb_word;

  arb_latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_cnt (
    .clk   (clk),
    .Reset (Reset),
    .i_load(w_cnt_load),
    .i_dec (w_cnt_dec),
    .o_zero(w_cnt_zero)
  );

`ifdef ARB_FETCH_REUSE_EN
  logic              r_fb_valid;
  logic [ADDR_W-1:0] r_fb_tag;
  logic [DATA_W-1:0] r_fb_word;

  // A pending write to the fetched address must reach memory first, so it forces a miss.
  assign w_hit = r_fb_valid && i_req && (r_fb_tag == i_addr) &&
                 !(d_req && d_we && (d_addr == i_addr));
  assign w_fb_word = r_fb_word;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_fb_valid <= 1'b0;
      r_fb_tag   <= '0;
      r_fb_word  <= '0;
    end else if (w_cap_i) begin
      r_fb_valid <= 1'b1;
      r_fb_tag   <= r_i_addr;
      r_fb_word  <= mem_rdata;
    end else if ((r_state == D_ACC) && r_d_we && (r_d_addr == r_fb_tag)) begin
      r_fb_valid <= 1'b0;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_fb_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state plus the memory-port values that the new state presents.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    w_mem_en_nx    = 1'b0;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_cap_d        = 1'b0;
    w_cap_i        = 1'b0;
    w_fb_use       = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req) begin
          w_state_nx     = D_ACC;
          w_cnt_load     = 1'b1;
          w_mem_en_nx    = 1'b1;
          w_mem_we_nx    = d_we;
          w_mem_addr_nx  = d_addr;
          w_mem_wdata_nx = d_wdata;
          w_fb_use       = w_hit;
        end else if (w_hit) begin
          w_state_nx = DONE;
          w_fb_use   = 1'b1;
        end else if (i_req) begin
          w_state_nx    = I_ACC;
          w_cnt_load    = 1'b1;
          w_mem_en_nx   = 1'b1;
          w_mem_addr_nx = i_addr;
        end
      end
      D_ACC: begin
        if (w_cnt_zero) begin
          w_cap_d = !r_d_we;
          if (r_i_req) begin
            w_state_nx    = I_ACC;
            w_cnt_load    = 1'b1;
            w_mem_en_nx   = 1'b1;
            w_mem_addr_nx = r_i_addr;
          end else begin
            w_state_nx = DONE;
          end
        end else begin
          w_cnt_dec   = 1'b1;
          w_mem_en_nx = 1'b1;
          w_mem_we_nx = r_d_we;
        end
      end
      I_ACC: begin
        if (w_cnt_zero) begin
          w_cap_i    = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_cnt_dec   = 1'b1;
          w_mem_en_nx = 1'b1;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_i_req     <= 1'b0;
      r_d_we      <= 1'b0;
      r_i_addr    <= '0;
      r_d_addr    <= '0;
      r_d_wdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_i_req   <= i_req && !w_hit;
        r_d_we    <= d_req && d_we;
        r_i_addr  <= i_addr;
        r_d_addr  <= d_addr;
        r_d_wdata <= d_wdata;
      end
      r_mem_en    <= w_mem_en_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      if (w_cap_d) r_d_rdata <= mem_rdata;
      if (w_cap_i)       r_i_rdata <= mem_rdata;
      else if (w_fb_use) r_i_rdata <= w_fb_word;
    end
  end

  assign stall     = Reset && (i_req || d_req) && (r_state != DONE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural single-ported memory.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        Reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_cmp;
  int n_err;

  int          cyc;
  logic [31:0] en_vec;
  logic [31:0] we_vec;
  logic [15:0] addr_rec [0:31];
  logic [15:0] wd_rec   [0:31];

  bit   [15:0] mem_arr [0:65535];
  bit          wr_flag [0:65535];

  unified_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    case (a)
      16'h0010: pat = 16'hABCD;
      16'h0011: pat = 16'h5678;
      16'h8000: pat = 16'h1234;
      default:  pat = a ^ 16'hA5A5;
    endcase
  endfunction

  assign mem_rdata = wr_flag[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr);

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one CPU cycle's requests and record the memory port until stall drops.
  task automatic run_txn(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
    cyc = 0; en_vec = '0; we_vec = '0;
    while (stall === 1'b1 && cyc < 20) begin
      en_vec[cyc]   = mem_en;
      we_vec[cyc]   = mem_we;
      addr_rec[cyc] = mem_addr;
      wd_rec[cyc]   = mem_wdata;
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20) begin n_err++; $display("FAIL stall_timeout: stall still high after %0d cycles", cyc); end
  endtask

  task automatic end_txn();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 16'h0010; d_addr = 16'h8000; d_wdata = 16'h0000;
    tick(); tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (i_rdata !== 16'h0) begin n_err++; $display("FAIL rst_i_rdata: got %h want 0000", i_rdata); end
    n_cmp++; if (d_rdata !== 16'h0) begin n_err++; $display("FAIL rst_d_rdata: got %h want 0000", d_rdata); end
    Reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_release_stall: got %b want 1", stall); end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", stall); end
    tick(); tick();
    n_cmp++; if (mem_en !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL idle_quiet: got en=%b stall=%b want 0 0", mem_en, stall); end
  endtask

  task automatic test_fetch_only();
    run_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL fetch_stall_len: got %0d want 3", cyc); end
    n_cmp++; if (en_vec[2:0] !== 3'b110) begin n_err++; $display("FAIL fetch_en_seq: got %b want 110", en_vec[2:0]); end
    n_cmp++; if (addr_rec[1] !== 16'h0010 || addr_rec[2] !== 16'h0010) begin n_err++; $display("FAIL fetch_addr: got %h %h want 0010 0010", addr_rec[1], addr_rec[2]); end
    n_cmp++; if (i_rdata !== 16'hABCD) begin n_err++; $display("FAIL fetch_rdata: got %h want abcd", i_rdata); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL fetch_done_en: got %b want 0", mem_en); end
    end_txn();
  endtask

  task automatic test_read_and_fetch();
    run_txn(1'b1, 16'h0011, 1'b1, 1'b0, 16'h8000, 16'h0000);
    n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL rf_stall_len: got %0d want 5", cyc); end
    n_cmp++; if (en_vec[4:0] !== 5'b11110 || we_vec[4:0] !== 5'b00000) begin n_err++; $display("FAIL rf_en_we: got en=%b we=%b want 11110 00000", en_vec[4:0], we_vec[4:0]); end
    n_cmp++; if (addr_rec[1] !== 16'h8000 || addr_rec[2] !== 16'h8000 || addr_rec[3] !== 16'h0011 || addr_rec[4] !== 16'h0011)
      begin n_err++; $display("FAIL rf_addr_seq: got %h %h %h %h want 8000 8000 0011 0011", addr_rec[1], addr_rec[2], addr_rec[3], addr_rec[4]); end
    n_cmp++; if (d_rdata !== 16'h1234) begin n_err++; $display("FAIL rf_d_rdata: got %h want 1234", d_rdata); end
    n_cmp++; if (i_rdata !== 16'h5678) begin n_err++; $display("FAIL rf_i_rdata: got %h want 5678", i_rdata); end
    end_txn();
  endtask

  task automatic test_write_then_fetch();
    run_txn(1'b1, 16'h8002, 1'b1, 1'b1, 16'h8002, 16'hBEEF);
    n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL wf_stall_len: got %0d want 5", cyc); end
    n_cmp++; if (we_vec[4:0] !== 5'b00110) begin n_err++; $display("FAIL wf_we_seq: got %b want 00110", we_vec[4:0]); end
    n_cmp++; if (wd_rec[1] !== 16'hBEEF || wd_rec[2] !== 16'hBEEF) begin n_err++; $display("FAIL wf_wdata: got %h %h want beef beef", wd_rec[1], wd_rec[2]); end
    n_cmp++; if (d_rdata !== 16'h1234) begin n_err++; $display("FAIL wf_d_rdata_hold: got %h want 1234", d_rdata); end
    n_cmp++; if (i_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wf_fetch_new: got %h want beef", i_rdata); end
    end_txn();
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 16'h0000, 1'b1, 1'b0, 16'h8002, 16'h0000);
    n_cmp++; if (cyc !== 3 || en_vec[2:0] !== 3'b110) begin n_err++; $display("FAIL b2b_len: got %0d/%b want 3/110", cyc, en_vec[2:0]); end
    n_cmp++; if (d_rdata !== 16'hBEEF) begin n_err++; $display("FAIL b2b_d_rdata: got %h want beef", d_rdata); end
    n_cmp++; if (i_rdata !== 16'hBEEF) begin n_err++; $display("FAIL b2b_i_hold: got %h want beef", i_rdata); end
    end_txn();
  endtask

  task automatic test_reset_mid_access();
    i_req = 1'b1; i_addr = 16'h0011; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8004; d_wdata = 16'h1111;
    tick();
    n_cmp++; if (mem_we !== 1'b1 || mem_en !== 1'b1) begin n_err++; $display("FAIL mid_dacc1: got en=%b we=%b want 1 1", mem_en, mem_we); end
    tick();
    Reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall_forced: got %b want 0", stall); end
    tick();
    n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL mid_mem_drop: got en=%b we=%b want 0 0", mem_en, mem_we); end
    n_cmp++; if (d_rdata !== 16'h0 || i_rdata !== 16'h0) begin n_err++; $display("FAIL mid_no_capture: got d=%h i=%h want 0000 0000", d_rdata, i_rdata); end
    Reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_idle_not_done: got %b want 1", stall); end
    end_txn();
  endtask

  task automatic test_fetch_reuse();
    run_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL reuse_fill_len: got %0d want 3", cyc); end
    end_txn();
    run_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
`ifdef ARB_FETCH_REUSE_EN
    n_cmp++; if (cyc !== 1 || en_vec[0] !== 1'b0) begin n_err++; $display("FAIL reuse_hit: got len=%0d en=%b want 1 0", cyc, en_vec[0]); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reuse_hit_en: got %b want 0", mem_en); end
`else
    n_cmp++; if (cyc !== 3 || en_vec[2:0] !== 3'b110) begin n_err++; $display("FAIL refetch_len: got %0d/%b want 3/110", cyc, en_vec[2:0]); end
`endif
    n_cmp++; if (i_rdata !== 16'hABCD) begin n_err++; $display("FAIL refetch_rdata: got %h want abcd", i_rdata); end
    end_txn();
    run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h4242);
    n_cmp++; if (cyc !== 3 || we_vec[2:0] !== 3'b110) begin n_err++; $display("FAIL inval_write: got %0d/%b want 3/110", cyc, we_vec[2:0]); end
    end_txn();
    run_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL inval_refetch_len: got %0d want 3", cyc); end
    n_cmp++; if (i_rdata !== 16'h4242) begin n_err++; $display("FAIL inval_refetch_rdata: got %h want 4242", i_rdata); end
    end_txn();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    Reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch_only();
    test_read_and_fetch();
    test_write_then_fetch();
    test_back_to_back();
    test_reset_mid_access();
    test_fetch_reuse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
